// File: rtl/mastermind_pkg.sv
// Shared Mastermind types: default geometry, peg colour, score record and
// scoring FSM state encoding.
package mastermind_pkg;

    localparam int unsigned DEFAULT_COLOR_W = 3;
    localparam int unsigned DEFAULT_NPEG    = 4;
    localparam int unsigned DEFAULT_CNT_W   = $clog2(DEFAULT_NPEG + 1);

    typedef logic [DEFAULT_COLOR_W-1:0] peg_t;

    typedef struct packed {
        logic [DEFAULT_CNT_W-1:0] black;
        logic [DEFAULT_CNT_W-1:0] white;
        logic                     win;
    } score_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StExact = 2'd1,
        StCross = 2'd2,
        StDone  = 2'd3
    } score_state_t;

endpackage

// File: rtl/score_accum.sv
// Scoring accumulator: per-peg used masks for code and guess plus the
// black/white match counters, all cleared together at the start of a score.
module score_accum #(
    parameter int unsigned NPEG  = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_code_idx,
    input  logic [IDX_W-1:0] set_guess_idx,
    input  logic             inc_black,
    input  logic             inc_white,
    output logic [NPEG-1:0]  code_used,
    output logic [NPEG-1:0]  guess_used,
    output logic [CNT_W-1:0] black,
    output logic [CNT_W-1:0] white
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            code_used  <= '0;
            guess_used <= '0;
            black      <= '0;
            white      <= '0;
        end else begin
            if (set_en) begin
                code_used[set_code_idx]   <= 1'b1;
                guess_used[set_guess_idx] <= 1'b1;
            end
            if (inc_black) black <= black + CNT_W'(1);
            if (inc_white) white <= white + CNT_W'(1);
        end
    end

    // Every match consumes one code peg, so the sum can never pass NPEG.
    black_bound_a: assert property (@(posedge clk) disable iff (reset)
        black <= CNT_W'(NPEG));
    white_bound_a: assert property (@(posedge clk) disable iff (reset)
        white <= CNT_W'(NPEG));
    total_bound_a: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, black} + {1'b0, white}) <= (CNT_W + 1)'(NPEG));

endmodule

// File: rtl/peg_score_sequencer.sv
// Mastermind scoring sequencer: exact pass, then colour-only cross pass, then a
// one-cycle done. Build option SCORE_EARLY_EXIT_EN skips the cross pass on all-black.
module peg_score_sequencer
    import mastermind_pkg::*;
#(
    parameter int unsigned COLOR_W = DEFAULT_COLOR_W,
    parameter int unsigned NPEG    = DEFAULT_NPEG,
    localparam int unsigned IDX_W  = $clog2(NPEG),
    localparam int unsigned CNT_W  = $clog2(NPEG + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [IDX_W-1:0]   code_idx,
    output logic [IDX_W-1:0]   guess_idx,
    input  logic [COLOR_W-1:0] code_peg,
    input  logic [COLOR_W-1:0] guess_peg,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   black,
    output logic [CNT_W-1:0]   white,
    output logic               win
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPEG - 1);

    score_state_t     state;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] c;

    logic [NPEG-1:0]  code_used;
    logic [NPEG-1:0]  guess_used;
    logic             pegs_eq;
    logic             exact_hit;
    logic             cross_hit;
    logic             cross_adv;
    logic             clear;

    always_comb begin
        code_idx  = '0;
        guess_idx = '0;
        unique case (state)
            StExact: begin
                code_idx  = i;
                guess_idx = i;
            end
            StCross: begin
                code_idx  = c;
                guess_idx = g;
            end
            default: ;
        endcase
    end

    always_comb begin
        pegs_eq   = (code_peg == guess_peg);
        exact_hit = (state == StExact) && pegs_eq;
        cross_hit = (state == StCross) && !guess_used[g] && !code_used[c] && pegs_eq;
        // Move on to the next guess peg once it is consumed or the code row is exhausted.
        cross_adv = (state == StCross) && (guess_used[g] || cross_hit || (c == LAST_IDX));
        clear     = (state == StIdle) && start;
    end

`ifdef SCORE_EARLY_EXIT_EN
    logic [CNT_W-1:0] black_after;
    assign black_after = black + CNT_W'(exact_hit);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            i     <= '0;
            g     <= '0;
            c     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            win   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StExact;
                        busy  <= 1'b1;
                        win   <= 1'b0;
                        i     <= '0;
                        g     <= '0;
                        c     <= '0;
                    end
                end
                StExact: begin
                    if (i == LAST_IDX) begin
                        i <= '0;
                        g <= '0;
                        c <= '0;
`ifdef SCORE_EARLY_EXIT_EN
                        if (black_after == CNT_W'(NPEG)) begin
                            state <= StDone;
                            done  <= 1'b1;
                            win   <= 1'b1;
                        end else begin
                            state <= StCross;
                        end
`else
                        state <= StCross;
`endif
                    end else begin
                        i <= i + IDX_W'(1);
                    end
                end
                StCross: begin
                    if (cross_adv) begin
                        c <= '0;
                        if (g == LAST_IDX) begin
                            g     <= '0;
                            state <= StDone;
                            done  <= 1'b1;
                            win   <= (black == CNT_W'(NPEG));
                        end else begin
                            g <= g + IDX_W'(1);
                        end
                    end else begin
                        c <= c + IDX_W'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    score_accum #(
        .NPEG  (NPEG),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_accum (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .set_en        (exact_hit || cross_hit),
        .set_code_idx  (code_idx),
        .set_guess_idx (guess_idx),
        .inc_black     (exact_hit),
        .inc_white     (cross_hit),
        .code_used     (code_used),
        .guess_used    (guess_used),
        .black         (black),
        .white         (white)
    );

endmodule

// File: tb/tb_peg_score_sequencer.sv
// Self-checking bench for peg_score_sequencer: directed and random codes scored
// against a count-based reference, with latency and index-walk expectations.
module tb_peg_score_sequencer;

    localparam int unsigned COLOR_W = 3;
    localparam int unsigned NPEG    = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [IDX_W-1:0]   code_idx;
    logic [IDX_W-1:0]   guess_idx;
    logic [COLOR_W-1:0] code_peg;
    logic [COLOR_W-1:0] guess_peg;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   black;
    logic [CNT_W-1:0]   white;
    logic               win;

    logic [COLOR_W-1:0] code_mem  [NPEG];
    logic [COLOR_W-1:0] guess_mem [NPEG];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pairs[$];
    int obs_pairs[$];

    always #5 clk = ~clk;

    assign code_peg  = code_mem[code_idx];
    assign guess_peg = guess_mem[guess_idx];

    peg_score_sequencer #(
        .COLOR_W (COLOR_W),
        .NPEG    (NPEG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .code_idx  (code_idx),
        .guess_idx (guess_idx),
        .code_peg  (code_peg),
        .guess_peg (guess_peg),
        .busy      (busy),
        .done      (done),
        .black     (black),
        .white     (white),
        .win       (win)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3,
                        input int g0, input int g1, input int g2, input int g3);
        code_mem[0]  = COLOR_W'(c0);
        code_mem[1]  = COLOR_W'(c1);
        code_mem[2]  = COLOR_W'(c2);
        code_mem[3]  = COLOR_W'(c3);
        guess_mem[0] = COLOR_W'(g0);
        guess_mem[1] = COLOR_W'(g1);
        guess_mem[2] = COLOR_W'(g2);
        guess_mem[3] = COLOR_W'(g3);
    endtask

    // Black/white from colour histograms; cross walk and latency from the pairing rules.
    task automatic model(output int eb, output int ew, output int edone);
        bit cu[NPEG];
        bit gu[NPEG];
        int hc[8];
        int hg[8];
        eb = 0;
        ew = 0;
        exp_pairs.delete();
        for (int k = 0; k < 8; k++) begin
            hc[k] = 0;
            hg[k] = 0;
        end
        for (int p = 0; p < NPEG; p++) begin
            cu[p] = 0;
            gu[p] = 0;
            hc[code_mem[p]]++;
            hg[guess_mem[p]]++;
            if (code_mem[p] == guess_mem[p]) begin
                eb++;
                cu[p] = 1;
                gu[p] = 1;
            end
        end
        for (int k = 0; k < 8; k++) ew += (hc[k] < hg[k]) ? hc[k] : hg[k];
        ew -= eb;
        for (int gi = 0; gi < NPEG; gi++) begin
            if (gu[gi]) begin
                exp_pairs.push_back(gi * 16);
            end else begin
                for (int ci = 0; ci < NPEG; ci++) begin
                    exp_pairs.push_back(gi * 16 + ci);
                    if (!cu[ci] && code_mem[ci] == guess_mem[gi]) begin
                        cu[ci] = 1;
                        gu[gi] = 1;
                        break;
                    end
                end
            end
        end
        edone = NPEG + exp_pairs.size() + 1;
`ifdef SCORE_EARLY_EXIT_EN
        if (eb == NPEG) begin
            exp_pairs.delete();
            edone = NPEG + 1;
        end
`endif
    endtask

    // Entered with start already high and the DUT idle; the next edge is E0.
    // Returns one cycle after done, sampled in the following IDLE cycle.
    task automatic run_score(input string tag, input bit hold);
        int eb, ew, edone;
        int got_done, busy_bad, idx_bad, seq_bad;
        model(eb, ew, edone);
        got_done = 0;
        busy_bad = 0;
        idx_bad  = 0;
        seq_bad  = 0;
        obs_pairs.delete();
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (!busy) busy_bad++;
            if (done) begin
                got_done = k;
                break;
            end
            if (k <= NPEG) begin
                if (int'(code_idx) != k - 1 || int'(guess_idx) != k - 1) idx_bad++;
            end else begin
                obs_pairs.push_back(int'(guess_idx) * 16 + int'(code_idx));
            end
            @(posedge clk);
            #1;
        end
        check({tag, ".done_cycle"}, got_done, edone);
        check({tag, ".busy"}, busy_bad, 0);
        check({tag, ".exact_idx"}, idx_bad, 0);
        check({tag, ".black"}, int'(black), eb);
        check({tag, ".white"}, int'(white), ew);
        check({tag, ".win"}, int'(win), (eb == NPEG) ? 1 : 0);
        check({tag, ".cross_len"}, obs_pairs.size(), exp_pairs.size());
        for (int k = 0; k < obs_pairs.size() && k < exp_pairs.size(); k++)
            if (obs_pairs[k] != exp_pairs[k]) seq_bad++;
        check({tag, ".cross_seq"}, seq_bad, 0);
        @(posedge clk);
        #1;
        check({tag, ".idle_busy"}, int'(busy), 0);
        check({tag, ".idle_done"}, int'(done), 0);
        check({tag, ".hold_black"}, int'(black), eb);
        check({tag, ".hold_white"}, int'(white), ew);
    endtask

    initial begin
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.black", int'(black), 0);
        check("rst.white", int'(white), 0);
        check("rst.win", int'(win), 0);
        check("rst.idx", int'(code_idx) + int'(guess_idx), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        load(1, 2, 3, 4, 1, 2, 3, 4);
        start = 1'b1;
        run_score("all_black", 1'b0);

        load(1, 2, 3, 4, 4, 3, 2, 1);
        start = 1'b1;
        run_score("all_white", 1'b0);

        load(1, 1, 2, 2, 1, 2, 1, 1);
        start = 1'b1;
        run_score("dups", 1'b0);

        load(5, 5, 5, 5, 0, 1, 2, 3);
        start = 1'b1;
        run_score("no_match", 1'b0);

        // start held through a whole score, then picked up again from IDLE
        load(2, 3, 2, 3, 3, 2, 3, 2);
        start = 1'b1;
        run_score("hold1", 1'b1);
        load(6, 7, 0, 1, 6, 0, 7, 1);
        run_score("hold2", 1'b0);

        // reset lands in the middle of the cross pass
        load(1, 2, 3, 4, 1, 5, 5, 5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.busy", int'(busy), 0);
        check("midrst.done", int'(done), 0);
        check("midrst.black", int'(black), 0);
        check("midrst.white", int'(white), 0);
        check("midrst.idx", int'(code_idx) + int'(guess_idx), 0);
        reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check("midrst.quiet", n_done, 0);
        load(1, 2, 3, 4, 1, 5, 4, 2);
        start = 1'b1;
        run_score("after_rst", 1'b0);

        for (int t = 0; t < 30; t++) begin
            int lim;
            lim = ($urandom_range(0, 1) == 0) ? 2 : 7;
            for (int p = 0; p < NPEG; p++) begin
                code_mem[p]  = COLOR_W'($urandom_range(0, lim));
                guess_mem[p] = COLOR_W'($urandom_range(0, lim));
            end
            start = 1'b1;
            run_score("rand", 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
